cordic_sched: RTL and testbench
===============================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15, meaning the maximum number of WAIT cycles before timeout (used only with CORDIC_SCHED_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports reqN_valid  input  1  request N present (N=0,1).
REQ-005 SHALL have ports reqN_ready  output  1  request N accepted this cycle.
REQ-006 SHALL have ports reqN_mode  input  1  0=rotation, 1=vectoring.
REQ-007 SHALL have ports reqN_val  input  10  operand (angle, or {x[4:0],y[4:0]}).
REQ-008 SHALL have port rsp_valid  output  1  response available.
REQ-009 SHALL have port rsp_ready  input  1  response consumed.
REQ-010 SHALL have port rsp_id  output  1  requester index of the response.
REQ-011 SHALL have port rsp_a  output  11  cosine/distance, signed, 9-bit fraction.
REQ-012 SHALL have port rsp_b  output  11  sine/arctan, signed, 9-bit fraction.
REQ-013 SHALL have port rsp_err  output  1  core timeout flag.
REQ-014 SHALL have port core_rst  output  1  restart pulse to the CORDIC core.
REQ-015 SHALL have ports core_mode  output  1 and core_in  output  10, operands driven to the core.
REQ-016 SHALL have port core_out_toggle  output  1  core result select (0=A, 1=B).
REQ-017 SHALL have port core_val  input  11  muxed core result.
REQ-018 SHALL have port core_done  input  1  core result valid.

Function
REQ-019 SHALL implement FSM states IDLE, KICK, WAIT, READ_A, READ_B, RESP.
REQ-020 SHALL assert reqN_ready combinationally only in IDLE, only for the granted requester, and never for both requesters in the same cycle.
REQ-021 SHALL grant round-robin: with both requests valid, grant the requester not granted last; with one valid, grant it.
REQ-022 SHALL, on reqN_valid & reqN_ready, register mode, val, and id, then go to KICK.
REQ-023 SHALL assert core_rst for exactly one cycle in KICK, then go to WAIT.
REQ-024 SHALL hold core_mode and core_in from the registered request from KICK through READ_B.
REQ-025 SHALL, in WAIT with core_done=1, go to READ_A.
REQ-026 SHALL, in READ_A, drive core_out_toggle=0 and capture core_val into rsp_a at the end of the cycle.
REQ-027 SHALL, in READ_B, drive core_out_toggle=1 and capture core_val into rsp_b.
REQ-028 SHALL raise rsp_valid 3 cycles after the first WAIT cycle with core_done=1.
REQ-029 SHALL hold rsp_valid, rsp_id, rsp_a, rsp_b, and rsp_err stable in RESP until rsp_ready=1, then return to IDLE.
REQ-030 SHALL NOT accept a new request in the cycle RESP completes; acceptance is possible no earlier than the next cycle.
REQ-031 SHALL ignore reqN_valid deassertion after acceptance; a captured request always completes.
REQ-032 SHALL leave the core otherwise unused when idle: core_rst=0 and core_out_toggle=0 outside KICK, READ_A, and READ_B.

Reset
REQ-033 SHALL, while rst=1, force reqN_ready=0 and core_rst=1 combinationally.
REQ-034 SHALL reset state to IDLE.
REQ-035 SHALL reset rsp_valid, rsp_id, rsp_a, rsp_b, rsp_err, core_mode, core_in, core_out_toggle, and the timeout counter to 0.
REQ-036 SHALL reset the last-grant pointer to 1, so requester 0 wins the first contention.
REQ-037 SHALL, on rst asserted in any state, drop any in-flight request without producing a response.

Configuration
REQ-038 SHALL, with CORDIC_SCHED_TIMEOUT_EN defined, count WAIT cycles.
REQ-039 SHALL, with CORDIC_SCHED_TIMEOUT_EN defined, on reaching TIMEOUT_CYC cycles without core_done, go to RESP with rsp_err=1 and rsp_a=rsp_b=0, skipping READ_A and READ_B.
REQ-040 SHALL, without CORDIC_SCHED_TIMEOUT_EN, omit the counter, tie rsp_err=0, and wait in WAIT indefinitely.

Verification
REQ-041 SHALL cover the single request: req0 mode=0 val=0x080, core model done 5 cycles after core_rst, core_val=0x155/0x0AA per toggle -> rsp_id=0, rsp_a=0x155, rsp_b=0x0AA, rsp_valid 3 cycles after done.
REQ-042 SHALL cover contention: req0 and req1 valid continuously from reset -> grants alternate 0,1,0,1 and no cycle has both ready signals high.
REQ-043 SHALL cover backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, no reqN_ready, one handshake when rsp_ready=1.
REQ-044 SHALL cover reset mid-operation: rst pulse during WAIT -> IDLE, core_rst=1 during rst, no response, next req1 served normally.
REQ-045 SHALL cover timeout with CORDIC_SCHED_TIMEOUT_EN: core_done held 0 -> after 15 WAIT cycles rsp_valid=1, rsp_err=1, rsp_a=rsp_b=0.
REQ-046 SHALL cover operand hold: req0 val=0x3E1 mode=1 -> core_in=0x3E1 and core_mode=1 held from KICK through READ_B.

Source files
------------

// File: rtl/cordic_sched_if.sv
// Handshake bundle between cordic_sched, its two requesters, the response sink and the CORDIC core.
interface cordic_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_mode;
    logic [9:0]  req0_val;
    logic        req1_valid;
    logic        req1_ready;
    logic        req1_mode;
    logic [9:0]  req1_val;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [10:0] rsp_a;
    logic [10:0] rsp_b;
    logic        rsp_err;
    logic        core_rst;
    logic        core_mode;
    logic [9:0]  core_in;
    logic        core_out_toggle;
    logic [10:0] core_val;
    logic        core_done;

    modport slave (
        input  req0_valid, req0_mode, req0_val,
        input  req1_valid, req1_mode, req1_val,
        input  rsp_ready, core_val, core_done,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_a, rsp_b, rsp_err,
        output core_rst, core_mode, core_in, core_out_toggle
    );

    modport master (
        output req0_valid, req0_mode, req0_val,
        output req1_valid, req1_mode, req1_val,
        output rsp_ready, core_val, core_done,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_a, rsp_b, rsp_err,
        input  core_rst, core_mode, core_in, core_out_toggle
    );
endinterface

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one CORDIC core between two requesters.
// Define CORDIC_SCHED_TIMEOUT_EN to abort a stuck core after TIMEOUT_CYC WAIT cycles.
module cordic_sched #(
    parameter int TIMEOUT_CYC = 15
) (
    input logic           clk,
    input logic           rst,
    cordic_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, KICK, WAIT, READ_A, READ_B, RESP} state_t;

    state_t      state_q, state_d;
    logic        lastGrant_q;
    logic        reqId_q;
    logic        reqMode_q;
    logic [9:0]  reqVal_q;
    logic [10:0] rspA_q;
    logic [10:0] rspB_q;
    logic        rspValid_q;
    logic        grant0, grant1, inIdle, accept, timeoutHit;

    // Requester 1 wins only when alone or when requester 0 won last time.
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !lastGrant_q);
    assign grant0 = bus.req0_valid && !grant1;
    assign inIdle = (state_q == IDLE) && !rst;
    assign accept = inIdle && (grant0 || grant1);

    assign bus.req0_ready      = inIdle && grant0;
    assign bus.req1_ready      = inIdle && grant1;
    assign bus.core_rst        = rst || (state_q == KICK);
    assign bus.core_out_toggle = (state_q == READ_B);
    assign bus.core_mode       = reqMode_q;
    assign bus.core_in         = reqVal_q;
    assign bus.rsp_valid       = rspValid_q;
    assign bus.rsp_id          = reqId_q;
    assign bus.rsp_a           = rspA_q;
    assign bus.rsp_b           = rspB_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = KICK;
            KICK:    state_d = WAIT;
            WAIT: begin
                if (bus.core_done) begin
                    state_d = READ_A;
                end else if (timeoutHit) begin
                    state_d = RESP;
                end
            end
            READ_A:  state_d = READ_B;
            READ_B:  state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant_q <= 1'b1;
            reqId_q     <= 1'b0;
            reqMode_q   <= 1'b0;
            reqVal_q    <= '0;
            rspA_q      <= '0;
            rspB_q      <= '0;
            rspValid_q  <= 1'b0;
        end else begin
            if (accept) begin
                reqId_q     <= grant1;
                lastGrant_q <= grant1;
                reqMode_q   <= grant1 ? bus.req1_mode : bus.req0_mode;
                reqVal_q    <= grant1 ? bus.req1_val : bus.req0_val;
            end
            // A timed-out request still answers, with zeroed results.
            if ((state_q == WAIT) && !bus.core_done && timeoutHit) begin
                rspA_q     <= '0;
                rspB_q     <= '0;
                rspValid_q <= 1'b1;
            end
            if (state_q == READ_A) begin
                rspA_q <= bus.core_val;
            end
            if (state_q == READ_B) begin
                rspB_q     <= bus.core_val;
                rspValid_q <= 1'b1;
            end
            if ((state_q == RESP) && bus.rsp_ready) begin
                rspValid_q <= 1'b0;
            end
        end
    end

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] timeoutCnt_q;
    logic            rspErr_q;

    assign timeoutHit  = (timeoutCnt_q == CntW'(TIMEOUT_CYC - 1));
    assign bus.rsp_err = rspErr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeoutCnt_q <= '0;
            rspErr_q     <= 1'b0;
        end else begin
            if (state_q == KICK) begin
                timeoutCnt_q <= '0;
            end else if (state_q == WAIT) begin
                timeoutCnt_q <= timeoutCnt_q + CntW'(1);
            end
            if (accept) begin
                rspErr_q <= 1'b0;
            end else if ((state_q == WAIT) && !bus.core_done && timeoutHit) begin
                rspErr_q <= 1'b1;
            end
        end
    end
`else
    assign timeoutHit  = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched with a behavioural CORDIC core and round-robin grant model.
module tb_cordic_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int          lastGrant = 1;
    int          coreLatency = 5;
    int          coreSince = 0;
    logic        coreArmed = 1'b0;
    logic [10:0] valA = 11'h155;
    logic [10:0] valB = 11'h0AA;

    cordic_sched_if bus();

    cordic_sched #(.TIMEOUT_CYC(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Core model: result valid coreLatency cycles after the restart pulse, held until the next one.
    always @(posedge clk) begin
        if (bus.core_rst) begin
            coreArmed <= 1'b1;
            coreSince <= 0;
        end else if (coreArmed) begin
            coreSince <= coreSince + 1;
        end
    end
    assign bus.core_done = coreArmed && (coreSince >= coreLatency - 1);
    assign bus.core_val  = bus.core_out_toggle ? valB : valA;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pickGrant(bit v0, bit v1);
        if (v0 && v1) return 1 - lastGrant;
        return v0 ? 0 : 1;
    endfunction

    task automatic driveReq(int id, logic v, logic m, logic [9:0] val);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_mode = m; bus.req0_val = val;
        end else begin
            bus.req1_valid = v; bus.req1_mode = m; bus.req1_val = val;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        driveReq(0, 1'b1, 1'b0, 10'h001);
        driveReq(1, 1'b1, 1'b1, 10'h002);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_ready got=%b exp=00", {bus.req1_ready, bus.req0_ready});
        end
        checks++;
        if (bus.core_rst !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_core_rst got=%b exp=1", bus.core_rst);
        end
        tick();
        rst = 1'b0;
        driveReq(0, 1'b0, 1'b0, 10'h000);
        driveReq(1, 1'b0, 1'b0, 10'h000);
        lastGrant = 1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_rsp_flags got=%b exp=000", {bus.rsp_valid, bus.rsp_id, bus.rsp_err});
        end
        checks++;
        if ({bus.rsp_a, bus.rsp_b} !== 22'h0) begin
            errors++; $display("[TB] FAIL reset_rsp_data got=%h/%h exp=0/0", bus.rsp_a, bus.rsp_b);
        end
        checks++;
        if ({bus.core_mode, bus.core_in} !== 11'h0) begin
            errors++; $display("[TB] FAIL reset_core_operands got=%b/%h exp=0/000", bus.core_mode, bus.core_in);
        end
        checks++;
        if ({bus.core_rst, bus.core_out_toggle} !== 2'b00) begin
            errors++; $display("[TB] FAIL idle_core_ctrl got=%b exp=00", {bus.core_rst, bus.core_out_toggle});
        end
    endtask

    task automatic test_single();
        int          id;
        int          lat;
        int          rspCycle;
        logic        mode;
        logic [9:0]  val;
        logic [10:0] a, b;
        for (int t = 0; t < 8; t++) begin
            if (t == 0) begin
                id = 0; mode = 1'b0; val = 10'h080; a = 11'h155; b = 11'h0AA; lat = 5;
            end else if (t == 1) begin
                id = 0; mode = 1'b1; val = 10'h3E1; a = 11'($urandom); b = 11'($urandom); lat = 3;
            end else begin
                id = $urandom_range(0, 1); mode = 1'($urandom_range(0, 1)); val = 10'($urandom);
                a = 11'($urandom); b = 11'($urandom); lat = $urandom_range(1, 8);
            end
            // KICK is relative cycle 1; core done lat cycles later; response three cycles after that.
            rspCycle = (1 + lat) + 3;
            tick();
            valA = a; valB = b; coreLatency = lat;
            driveReq(id, 1'b1, mode, val);
            @(negedge clk);
            checks++;
            if ({bus.req1_ready, bus.req0_ready} !== ((id == 1) ? 2'b10 : 2'b01)) begin
                errors++; $display("[TB] FAIL single_grant t=%0d got=%b exp_id=%0d", t, {bus.req1_ready, bus.req0_ready}, id);
            end
            lastGrant = id;
            tick();
            driveReq(id, 1'b0, ~mode, ~val);
            for (int c = 1; c <= rspCycle; c++) begin
                @(negedge clk);
                if (c < rspCycle) begin
                    checks++;
                    if ({bus.core_rst, bus.core_out_toggle, bus.rsp_valid} !== {c == 1, c == rspCycle - 1, 1'b0}) begin
                        errors++; $display("[TB] FAIL single_core_ctrl t=%0d c=%0d got=%b exp=%b", t, c,
                            {bus.core_rst, bus.core_out_toggle, bus.rsp_valid}, {c == 1, c == rspCycle - 1, 1'b0});
                    end
                    checks++;
                    if ({bus.core_mode, bus.core_in} !== {mode, val}) begin
                        errors++; $display("[TB] FAIL operand_hold t=%0d c=%0d got=%b/%h exp=%b/%h", t, c, bus.core_mode, bus.core_in, mode, val);
                    end
                end else begin
                    checks++;
                    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== {1'b1, id[0], 1'b0}) begin
                        errors++; $display("[TB] FAIL single_rsp_flags t=%0d got=%b exp=%b", t, {bus.rsp_valid, bus.rsp_id, bus.rsp_err}, {1'b1, id[0], 1'b0});
                    end
                    checks++;
                    if ({bus.rsp_a, bus.rsp_b} !== {a, b}) begin
                        errors++; $display("[TB] FAIL single_rsp_data t=%0d got=%h/%h exp=%h/%h", t, bus.rsp_a, bus.rsp_b, a, b);
                    end
                end
            end
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL single_rsp_drop t=%0d got=%b exp=0", t, bus.rsp_valid);
            end
        end
    endtask

    task automatic test_contention();
        logic [9:0] v0, v1;
        int         exp;
        bit         seen;
        v0 = 10'($urandom);
        v1 = v0 ^ 10'h2A5;
        valA = 11'($urandom); valB = 11'($urandom); coreLatency = 3;
        tick();
        rst = 1'b1;
        driveReq(0, 1'b1, 1'b1, v0);
        driveReq(1, 1'b1, 1'b0, v1);
        tick(); tick();
        rst = 1'b0;
        lastGrant = 1;
        for (int n = 0; n < 4; n++) begin
            exp = pickGrant(1'b1, 1'b1);
            seen = 1'b0;
            for (int w = 0; w < 40 && !seen; w++) begin
                @(negedge clk);
                checks++;
                if (bus.req0_ready && bus.req1_ready) begin
                    errors++; $display("[TB] FAIL both_ready n=%0d got=11 exp=not_both", n);
                end
                if (bus.req0_ready || bus.req1_ready) begin
                    seen = 1'b1;
                    checks++;
                    if (bus.req1_ready !== exp[0]) begin
                        errors++; $display("[TB] FAIL contention_grant n=%0d got=%b exp=%0d", n, bus.req1_ready, exp);
                    end
                end
            end
            checks++;
            if (!seen) begin
                errors++; $display("[TB] FAIL contention_grant_wait n=%0d got=none exp=%0d", n, exp);
            end
            lastGrant = exp;
            seen = 1'b0;
            for (int w = 0; w < 40 && !seen; w++) begin
                @(negedge clk);
                if (w == 0) begin
                    checks++;
                    if (bus.core_in !== ((exp == 1) ? v1 : v0)) begin
                        errors++; $display("[TB] FAIL contention_operand n=%0d got=%h exp=%h", n, bus.core_in, (exp == 1) ? v1 : v0);
                    end
                end
                checks++;
                if (bus.req0_ready || bus.req1_ready) begin
                    errors++; $display("[TB] FAIL busy_ready n=%0d got=%b exp=00", n, {bus.req1_ready, bus.req0_ready});
                end
                if (bus.rsp_valid === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++; $display("[TB] FAIL contention_rsp_wait n=%0d got=none exp=rsp", n);
            end
            checks++;
            if ({bus.rsp_id, bus.rsp_a, bus.rsp_b} !== {exp[0], valA, valB}) begin
                errors++; $display("[TB] FAIL contention_rsp n=%0d got=%b/%h/%h exp=%0d/%h/%h", n, bus.rsp_id, bus.rsp_a, bus.rsp_b, exp, valA, valB);
            end
        end
        driveReq(0, 1'b0, 1'b0, 10'h000);
        driveReq(1, 1'b0, 1'b0, 10'h000);
    endtask

    task automatic test_back_to_back_backpressure();
        logic [9:0] v;
        logic       m;
        bit         seen;
        int         hs;
        int         exp;
        v = 10'($urandom); m = 1'($urandom_range(0, 1));
        valA = 11'($urandom); valB = 11'($urandom); coreLatency = $urandom_range(1, 6);
        tick();
        bus.rsp_ready = 1'b0;
        driveReq(1, 1'b1, m, v);
        @(negedge clk);
        lastGrant = pickGrant(1'b0, 1'b1);
        tick();
        driveReq(1, 1'b0, m, v);
        seen = 1'b0;
        for (int w = 0; w < 30 && !seen; w++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL bp_rsp_wait got=none exp=rsp");
        end
        driveReq(0, 1'b1, 1'b0, 10'h155);
        driveReq(1, 1'b1, 1'b1, 10'h0AA);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_a, bus.rsp_b, bus.rsp_err} !== {1'b1, 1'b1, valA, valB, 1'b0}) begin
                errors++; $display("[TB] FAIL bp_hold k=%0d got=%b/%b/%h/%h/%b exp=1/1/%h/%h/0", k,
                    bus.rsp_valid, bus.rsp_id, bus.rsp_a, bus.rsp_b, bus.rsp_err, valA, valB);
            end
            checks++;
            if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
                errors++; $display("[TB] FAIL bp_ready k=%0d got=%b exp=00", k, {bus.req1_ready, bus.req0_ready});
            end
            @(negedge clk);
        end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL bp_ready_on_release got=%b exp=00", {bus.req1_ready, bus.req0_ready});
        end
        hs = (bus.rsp_valid && bus.rsp_ready) ? 1 : 0;
        @(negedge clk);
        exp = pickGrant(1'b1, 1'b1);
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== ((exp == 1) ? 2'b10 : 2'b01)) begin
            errors++; $display("[TB] FAIL bp_next_grant got=%b exp_id=%0d", {bus.req1_ready, bus.req0_ready}, exp);
        end
        driveReq(0, 1'b0, 1'b0, 10'h000);
        driveReq(1, 1'b0, 1'b0, 10'h000);
        for (int k = 0; k < 5; k++) begin
            if (bus.rsp_valid && bus.rsp_ready) hs++;
            @(negedge clk);
        end
        checks++;
        if (hs !== 1) begin
            errors++; $display("[TB] FAIL bp_handshakes got=%0d exp=1", hs);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] v;
        bit         seen;
        coreLatency = 1000;
        tick();
        driveReq(0, 1'b1, 1'b0, 10'($urandom));
        @(negedge clk);
        lastGrant = 0;
        tick();
        driveReq(0, 1'b0, 1'b0, 10'h000);
        tick(); tick();
        rst = 1'b1;
        driveReq(0, 1'b1, 1'b0, 10'h011);
        driveReq(1, 1'b1, 1'b0, 10'h022);
        @(negedge clk);
        checks++;
        if ({bus.core_rst, bus.req1_ready, bus.req0_ready, bus.rsp_valid} !== 4'b1000) begin
            errors++; $display("[TB] FAIL midreset_outputs got=%b exp=1000", {bus.core_rst, bus.req1_ready, bus.req0_ready, bus.rsp_valid});
        end
        tick();
        rst = 1'b0;
        driveReq(0, 1'b0, 1'b0, 10'h000);
        driveReq(1, 1'b0, 1'b0, 10'h000);
        lastGrant = 1;
        seen = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("[TB] FAIL midreset_no_rsp got=rsp exp=none");
        end
        v = 10'($urandom);
        valA = 11'($urandom); valB = 11'($urandom); coreLatency = 4;
        tick();
        driveReq(1, 1'b1, 1'b1, v);
        @(negedge clk);
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            errors++; $display("[TB] FAIL midreset_req1_grant got=%b exp=10", {bus.req1_ready, bus.req0_ready});
        end
        lastGrant = 1;
        tick();
        driveReq(1, 1'b0, 1'b1, v);
        seen = 1'b0;
        for (int w = 0; w < 30 && !seen; w++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL midreset_rsp_wait got=none exp=rsp");
        end
        checks++;
        if ({bus.rsp_id, bus.rsp_a, bus.rsp_b, bus.rsp_err} !== {1'b1, valA, valB, 1'b0}) begin
            errors++; $display("[TB] FAIL midreset_rsp got=%b/%h/%h/%b exp=1/%h/%h/0", bus.rsp_id, bus.rsp_a, bus.rsp_b, bus.rsp_err, valA, valB);
        end
        @(negedge clk);
    endtask

`ifdef CORDIC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int rspCycle;
        // KICK, then fifteen WAIT cycles, then the error response.
        rspCycle = 1 + 15 + 1;
        coreLatency = 100000;
        bus.rsp_ready = 1'b1;
        tick();
        driveReq(0, 1'b1, 1'b1, 10'h1C3);
        @(negedge clk);
        lastGrant = pickGrant(1'b1, 1'b0);
        tick();
        driveReq(0, 1'b0, 1'b0, 10'h000);
        for (int c = 1; c <= rspCycle; c++) begin
            @(negedge clk);
            if (c < rspCycle) begin
                checks++;
                if ({bus.rsp_valid, bus.core_out_toggle} !== 2'b00) begin
                    errors++; $display("[TB] FAIL timeout_wait c=%0d got=%b exp=00", c, {bus.rsp_valid, bus.core_out_toggle});
                end
            end else begin
                checks++;
                if ({bus.rsp_valid, bus.rsp_err, bus.rsp_a, bus.rsp_b} !== {1'b1, 1'b1, 22'h0}) begin
                    errors++; $display("[TB] FAIL timeout_rsp got=%b/%b/%h/%h exp=1/1/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_a, bus.rsp_b);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_rsp_drop got=%b exp=0", bus.rsp_valid);
        end
    endtask
`else
    task automatic test_no_timeout();
        bit seen;
        coreLatency = 100000;
        bus.rsp_ready = 1'b1;
        tick();
        driveReq(0, 1'b1, 1'b0, 10'h1C3);
        @(negedge clk);
        lastGrant = pickGrant(1'b1, 1'b0);
        tick();
        driveReq(0, 1'b0, 1'b0, 10'h000);
        seen = 1'b0;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if ((bus.rsp_valid !== 1'b0) || (bus.rsp_err !== 1'b0)) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("[TB] FAIL no_timeout_wait got=rsp exp=none");
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lastGrant = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back_backpressure();
        test_reset_mid();
`ifdef CORDIC_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
